// File: rtl/fifo_rr_drain_pkg.sv
// Shared types and helpers for the round-robin FIFO drain scheduler.
package fifo_rr_drain_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StXfer = 1'b1
    } state_e;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // Channel index width, at least one bit.
    function automatic int unsigned calc_cw(input int unsigned n);
        return (n <= 2) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first asserted request at or after ptr_i, wrapping.
module rr_pick import fifo_rr_drain_pkg::*; #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = calc_cw(NCH)
) (
    input  logic [NCH-1:0] req_i,
    input  logic [CW-1:0]  ptr_i,
    output logic           any_o,
    output logic [CW-1:0]  idx_o
);

    logic [CW-1:0] cand;

    // Scan offsets high to low so the smallest offset from ptr_i wins.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            cand = CW'((int'(ptr_i) + k) % int'(NCH));
            if (req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_drain.sv
// Round-robin drain of NCH FWFT FIFOs into one registered valid/ready stream.
module fifo_rr_drain import fifo_rr_drain_pkg::*; #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned DW    = 64,
    parameter int unsigned AW    = 5,
    parameter int unsigned BURST = 8,
    localparam int unsigned CW   = calc_cw(NCH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        ch_empty,
    input  logic [NCH*(AW+1)-1:0] ch_cntr,
    input  logic [NCH*DW-1:0]     ch_fwft_dout,
    output logic [NCH-1:0]        ch_rd,
    output logic [DW-1:0]         out_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [CW-1:0]         out_ch,
    output logic                  busy
);

    localparam int unsigned CNTW = AW + 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   grant_q, grant_d;
    logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0] beat_cnt_q, beat_cnt_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic [CW-1:0]   out_ch_q, out_ch_d;
    logic [DW-1:0]   out_dout_q, out_dout_d;

    logic [CNTW-1:0] cntr_arr [NCH];
    logic [DW-1:0]   dout_arr [NCH];
    logic [NCH-1:0]  eligible;
    logic            pick_any;
    logic [CW-1:0]   pick_idx;
    logic            slot_free;
    logic            rd_en;
    logic            last_word;

    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign cntr_arr[i] = ch_cntr[i*CNTW +: CNTW];
        assign dout_arr[i] = ch_fwft_dout[i*DW +: DW];
    end

    assign eligible  = ~ch_empty;
    assign slot_free = !out_valid_q || out_ready;
    // A burst ends on the BURST-th word or on the last word stored right now;
    // a concurrent write only becomes visible after this read.
    assign last_word = (beat_cnt_q == CNTW'(BURST - 1)) || (cntr_arr[grant_q] == CNTW'(1));

    rr_pick #(
        .NCH (NCH),
        .CW  (CW)
    ) u_pick (
        .req_i (eligible),
        .ptr_i (rr_ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    // Next-state: arbitration in IDLE, word transfer and output stage in XFER.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        out_dout_d  = out_dout_q;
        rd_en       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    grant_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = StXfer;
                end
            end
            StXfer: begin
                // Never read an empty FIFO: sc_fifo has no underflow guard.
                if (slot_free && !ch_empty[grant_q]) begin
                    rd_en       = 1'b1;
                    out_dout_d  = dout_arr[grant_q];
                    out_ch_d    = grant_q;
                    out_valid_d = 1'b1;
                    out_last_d  = last_word;
                    beat_cnt_d  = beat_cnt_q + CNTW'(1);
                    if (last_word) begin
                        state_d  = StIdle;
                        rr_ptr_d = (grant_q == CW'(NCH - 1)) ? '0 : grant_q + CW'(1);
                    end
                end
            end
        endcase

        if (!rd_en && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
            out_dout_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
            out_dout_q  <= out_dout_d;
        end
    end

    assign ch_rd     = rd_en ? (NCH'(1) << grant_q) : '0;
    assign out_dout  = out_dout_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;
    assign busy      = (state_q == StXfer);

endmodule
